// File: rtl/hasti_sram.sv
// ---------------------------------------------------------------------------
// hasti_sram -- AHB-Lite (HASTI) single-port SRAM slave.
//
// Holds 2**(ADDR_WIDTH-2) 32-bit words. Each accepted transfer gets a data
// phase stretched by WAIT_STATES wait cycles. Writes land in the array on
// the edge that completes the data phase, using little-endian byte enables
// derived from the captured address and size. Read data is driven only in
// the completing cycle and is zero otherwise.
//
// Optional feature (macro HASTI_SRAM_ERR_EN):
//   defined   : hsize>2 or misaligned halfword/word accesses get a two-cycle
//               ERROR response and never write the array.
//   undefined : hsize>2 is treated as a word, misaligned low address bits are
//               ignored (natural alignment), hresp is always OKAY.
//
// Parameters:
//   ADDR_WIDTH   byte-address bits decoded (higher bits ignored, wrap-around)
//   WAIT_STATES  wait cycles per OKAY data phase, 0..7
//
// Ports:
//   hclk       clock, rising edge
//   hresetn    asynchronous active-low reset
//   hsel       slave select
//   haddr      byte address
//   hwrite     1 = write, 0 = read
//   hsize      0 byte, 1 halfword, 2 word
//   hburst     ignored
//   hprot      ignored
//   hmastlock  ignored
//   htrans     IDLE/BUSY/NONSEQ/SEQ
//   hready     bus-wide ready (address phase accepted only when high)
//   hwdata     write data, valid in the data phase
//   hrdata     read data
//   hreadyout  this slave's ready
//   hresp      0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module hasti_sram #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } state_t;

    state_t             state;
    logic [2:0]         cnt;

    logic [IDX_W-1:0]   word_addr;
    logic [3:0]         byte_en_r;
    logic               is_write;

    logic [31:0]        mem [0:WORDS-1];

    logic               accept;
    logic               dp_done;
    logic               can_take;
    logic               take;
    logic               req_err;

    state_t             start_state;
    logic [2:0]         start_cnt;
    logic               start_rdy;
    logic               start_resp;

    // Little-endian lane selection. Halfword uses only bit 1 and word uses
    // neither, so misaligned low bits are cleared to natural alignment.
    function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] en;
        case (size)
            3'd0:    en = 4'b0001 << lo;
            3'd1:    en = lo[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    assign accept   = hsel & hready & htrans[1];
    assign dp_done  = (state == WAIT) && (cnt == 3'd0);
    // Only a cycle that ends with hreadyout high can close an address phase.
    assign can_take = (state == IDLE) || (state == ERR2) || dp_done;
    assign take     = accept & can_take;

`ifdef HASTI_SRAM_ERR_EN
    assign req_err = (hsize > 3'd2)
                   || ((hsize == 3'd1) && haddr[0])
                   || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
`else
    assign req_err = 1'b0;
`endif

    // Where a freshly accepted transfer sends the FSM.
    always_comb begin
        start_state = WAIT;
        start_cnt   = 3'(WAIT_STATES);
        start_rdy   = (WAIT_STATES == 0);
        start_resp  = 1'b0;
        if (req_err) begin
            start_state = ERR1;
            start_cnt   = 3'd0;
            start_rdy   = 1'b0;
            start_resp  = 1'b1;
        end
    end

    // Control FSM; hreadyout and hresp are registered alongside the state.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt       <= cnt - 3'd1;
                        // Ready rises together with the counter reaching zero.
                        hreadyout <= (cnt == 3'd1);
                    end else if (take) begin
                        state     <= start_state;
                        cnt       <= start_cnt;
                        hreadyout <= start_rdy;
                        hresp     <= start_resp;
                    end else begin
                        state     <= IDLE;
                        cnt       <= 3'd0;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    // IDLE and the second ERROR cycle both accept new work.
                    if (take) begin
                        state     <= start_state;
                        cnt       <= start_cnt;
                        hreadyout <= start_rdy;
                        hresp     <= start_resp;
                    end else begin
                        state     <= IDLE;
                        cnt       <= 3'd0;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Address phase -> data phase: capture the transfer attributes.
    always_ff @(posedge hclk) begin
        if (take) begin
            word_addr <= haddr[ADDR_WIDTH-1:2];
            byte_en_r <= lane_en(hsize, haddr[1:0]);
            is_write  <= hwrite;
        end
    end

    // Data phase completion: commit enabled byte lanes.
    always_ff @(posedge hclk) begin
        if (dp_done && is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_r[b]) begin
                    mem[word_addr][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    // Reset forces IDLE, so read data drops to zero asynchronously as well.
    assign hrdata = (dp_done && !is_write) ? mem[word_addr] : 32'h0;

    logic unused_inputs;
    assign unused_inputs = ^{1'b0, haddr[31:ADDR_WIDTH], hburst, hprot, hmastlock, htrans[0]};

endmodule
